neuron_dot_seq: RTL and testbench

Sequencing and accumulation stage placed directly upstream of the combinational `macc` unit in the neural datapath. It accepts a stream of (activation, weight) pairs over a valid/ready handshake and drives each pair into `macc` together with its running accumulator. It registers the `macc` result back into that accumulator and, after `LEN` pairs, emits the finished dot product on a valid/ready output. `macc` is instantiated outside this block; its three inputs and its output connect to the `macc_*` ports.

---
 rtl/neuron_dot_seq_if.sv | 31 +++
 rtl/neuron_dot_seq.sv | 90 +++++++++
 tb/tb_neuron_dot_seq.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/neuron_dot_seq_if.sv
// neuron_dot_seq_if: handshake and macc-side signal bundle for neuron_dot_seq.
//   Input stream : in_valid, in_ready, in_x, in_w
//   macc link    : macc_in0, macc_in1, macc_acc (to macc), macc_out (from macc)
//   Output stream: out_valid, out_ready, out_data
// Modports: slave = the neuron_dot_seq block, master = the surrounding environment
// (stream producer, consumer and the external macc unit).
interface neuron_dot_seq_if #(
   parameter int unsigned WIDTH = 16
);
   logic                    in_valid;
   logic                    in_ready;
   logic signed [WIDTH-1:0] in_x;
   logic signed [WIDTH-1:0] in_w;
   logic signed [WIDTH-1:0] macc_in0;
   logic signed [WIDTH-1:0] macc_in1;
   logic signed [WIDTH-1:0] macc_acc;
   logic signed [WIDTH-1:0] macc_out;
   logic                    out_valid;
   logic                    out_ready;
   logic signed [WIDTH-1:0] out_data;

   modport slave (
      input  in_valid, in_x, in_w, macc_out, out_ready,
      output in_ready, macc_in0, macc_in1, macc_acc, out_valid, out_data
   );

   modport master (
      output in_valid, in_x, in_w, macc_out, out_ready,
      input  in_ready, macc_in0, macc_in1, macc_acc, out_valid, out_data
   );
endinterface

// File: rtl/neuron_dot_seq.sv
// neuron_dot_seq: sequences LEN (activation, weight) pairs into an external
// combinational macc, accumulates its result and emits the dot product.
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset
//   bus  - neuron_dot_seq_if.slave (input stream, macc link, output stream)
// Parameters: WIDTH (data width, signed), LEN (pairs per dot product, 2..256).
// Option: define NEURON_RELU_EN to clamp negative results to zero on write to res.
module neuron_dot_seq #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned LEN   = 8
) (
   input  logic              clk,
   input  logic              rst,
   neuron_dot_seq_if.slave   bus
);

   localparam int unsigned CNT_W = (LEN > 1) ? $clog2(LEN) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LEN - 1);

   typedef enum logic {
      ACCUM = 1'b0,
      DONE  = 1'b1
   } state_t;

   state_t                  state;
   logic signed [WIDTH-1:0] acc;
   logic signed [WIDTH-1:0] res;
   logic [CNT_W-1:0]        cnt;
   logic                    in_ready_q;
   logic                    out_valid_q;
   logic signed [WIDTH-1:0] res_next;

   // macc operands are pure wiring; macc itself lives outside this block.
   assign bus.macc_in0  = bus.in_x;
   assign bus.macc_in1  = bus.in_w;
   assign bus.macc_acc  = acc;
   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = res;

   // Value captured into res on completion; acc always takes the raw sum.
   always_comb begin
      res_next = bus.macc_out;
`ifdef NEURON_RELU_EN
      if (bus.macc_out[WIDTH-1]) begin
         res_next = '0;
      end
`endif
   end

   // State machine with registered handshake outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= ACCUM;
         acc         <= '0;
         cnt         <= '0;
         res         <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
      end else begin
         case (state)
            ACCUM: begin
               if (bus.in_valid && in_ready_q) begin
                  if (cnt == CNT_LAST) begin
                     res         <= res_next;
                     acc         <= '0;
                     cnt         <= '0;
                     state       <= DONE;
                     in_ready_q  <= 1'b0;
                     out_valid_q <= 1'b1;
                  end else begin
                     acc <= bus.macc_out;
                     cnt <= cnt + CNT_W'(1);
                  end
               end
            end
            DONE: begin
               // Input is ignored here; res stays until the next completion.
               if (out_valid_q && bus.out_ready) begin
                  state       <= ACCUM;
                  in_ready_q  <= 1'b1;
                  out_valid_q <= 1'b0;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_neuron_dot_seq.sv
// tb_neuron_dot_seq: directed self-checking bench for neuron_dot_seq with LEN=4.
// Hosts a behavioural macc (in0*in1+acc, truncated) on the interface.
module tb_neuron_dot_seq;

   localparam int unsigned WIDTH = 16;
   localparam int unsigned LEN   = 4;

   logic clk;
   logic rst;
   int   tests;
   int   fails;

   neuron_dot_seq_if #(.WIDTH(WIDTH)) bus ();

   neuron_dot_seq #(.WIDTH(WIDTH), .LEN(LEN)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // External macc: product and sum both wrap modulo 2^WIDTH.
   assign bus.macc_out = bus.macc_in0 * bus.macc_in1 + bus.macc_acc;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [63:0] pack4(input int a, input int b, input int c, input int d);
      return {16'(d), 16'(c), 16'(b), 16'(a)};
   endfunction

   // Drive four pairs at negedges (gap idle cycles before each); optionally check macc_acc.
   task automatic feed(input logic [63:0] xs, input logic [63:0] ws, input int gap,
                       input logic chk_acc, input logic [63:0] accs);
      for (int i = 0; i < 4; i++) begin
         for (int g = 0; g < gap; g++) begin
            @(negedge clk);
            bus.in_valid = 1'b0;
            bus.in_x     = 16'h7777;
            bus.in_w     = 16'h7777;
         end
         @(negedge clk);
         bus.in_valid = 1'b1;
         bus.in_x     = xs[16*i +: 16];
         bus.in_w     = ws[16*i +: 16];
         #1;
         tests++;
         if (bus.in_ready !== 1'b1) begin
            fails++;
            $display("FAIL feed_in_ready[%0d]: got %b expected 1", i, bus.in_ready);
         end
         if (chk_acc) begin
            tests++;
            if (bus.macc_acc !== accs[16*i +: 16]) begin
               fails++;
               $display("FAIL macc_acc[%0d]: got %0d expected %0d", i,
                        $signed(bus.macc_acc), $signed(accs[16*i +: 16]));
            end
         end
      end
      @(negedge clk);
      bus.in_valid = 1'b0;
   endtask

   // Checks the cycle after the final accept, then the handshake cycle with out_ready=1.
   task automatic check_result(input string name, input logic [15:0] exp);
      #1;
      tests++;
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
         fails++;
         $display("FAIL %s_valid: got out_valid=%b in_ready=%b expected 1/0", name,
                  bus.out_valid, bus.in_ready);
      end
      tests++;
      if (bus.out_data !== exp) begin
         fails++;
         $display("FAIL %s_data: got %0d expected %0d", name, $signed(bus.out_data), $signed(exp));
      end
      @(negedge clk);
      #1;
      tests++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.out_data !== exp) begin
         fails++;
         $display("FAIL %s_after: got out_valid=%b in_ready=%b data=%0d expected 0/1/%0d", name,
                  bus.out_valid, bus.in_ready, $signed(bus.out_data), $signed(exp));
      end
   endtask

   task automatic test_reset;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      #1;
      tests++;
      if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
         fails++;
         $display("FAIL reset_hs: got in_ready=%b out_valid=%b expected 1/0", bus.in_ready, bus.out_valid);
      end
      tests++;
      if (bus.out_data !== 16'd0 || bus.macc_acc !== 16'd0) begin
         fails++;
         $display("FAIL reset_data: got out_data=%0d macc_acc=%0d expected 0/0",
                  $signed(bus.out_data), $signed(bus.macc_acc));
      end
   endtask

   task automatic test_basic;
      feed(pack4(10, 70, -7, 1), pack4(15, 8, 5, 1), 0, 1'b1, pack4(0, 150, 710, 675));
      check_result("basic", 16'd676);
   endtask

   task automatic test_negative;
      feed(pack4(-7, 0, 0, 0), pack4(5, 0, 0, 0), 0, 1'b1, pack4(0, -35, -35, -35));
`ifdef NEURON_RELU_EN
      check_result("negative", 16'd0);
`else
      check_result("negative", 16'hFFDD);
`endif
   endtask

   task automatic test_wrap;
      feed(pack4(200, 200, 200, 200), pack4(200, 200, 200, 200), 0, 1'b1,
           pack4(0, -25536, 14464, -11072));
      check_result("wrap", 16'd28928);
   endtask

   task automatic test_gaps;
      feed(pack4(10, 70, -7, 1), pack4(15, 8, 5, 1), 1, 1'b1, pack4(0, 150, 710, 675));
      check_result("gaps", 16'd676);
   endtask

   task automatic test_backpressure;
      bus.out_ready = 1'b0;
      feed(pack4(3, 4, 5, 6), pack4(1, 1, 1, 1), 0, 1'b0, 64'd0);
      // Offer a pair that must not be consumed while DONE waits.
      bus.in_valid = 1'b1;
      bus.in_x     = 16'd100;
      bus.in_w     = 16'd100;
      for (int c = 0; c < 3; c++) begin
         #1;
         tests++;
         if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.out_data !== 16'd18) begin
            fails++;
            $display("FAIL bp_hold[%0d]: got out_valid=%b in_ready=%b data=%0d expected 1/0/18", c,
                     bus.out_valid, bus.in_ready, $signed(bus.out_data));
         end
         @(negedge clk);
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      @(negedge clk);
      #1;
      tests++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.macc_acc !== 16'd0) begin
         fails++;
         $display("FAIL bp_release: got out_valid=%b in_ready=%b macc_acc=%0d expected 0/1/0",
                  bus.out_valid, bus.in_ready, $signed(bus.macc_acc));
      end
      feed(pack4(10, 70, -7, 1), pack4(15, 8, 5, 1), 0, 1'b1, pack4(0, 150, 710, 675));
      check_result("bp_next", 16'd676);
   endtask

   task automatic test_reset_mid;
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_x     = 16'd5;
      bus.in_w     = 16'd5;
      @(negedge clk);
      bus.in_x     = 16'd3;
      bus.in_w     = 16'd3;
      @(negedge clk);
      bus.in_valid = 1'b0;
      #1;
      tests++;
      if (bus.macc_acc !== 16'd34) begin
         fails++;
         $display("FAIL mid_partial: got %0d expected 34", $signed(bus.macc_acc));
      end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      #1;
      tests++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 ||
          bus.out_data !== 16'd0 || bus.macc_acc !== 16'd0) begin
         fails++;
         $display("FAIL mid_reset: got out_valid=%b in_ready=%b data=%0d acc=%0d expected 0/1/0/0",
                  bus.out_valid, bus.in_ready, $signed(bus.out_data), $signed(bus.macc_acc));
      end
      feed(pack4(10, 70, -7, 1), pack4(15, 8, 5, 1), 0, 1'b1, pack4(0, 150, 710, 675));
      check_result("mid_vec", 16'd676);
   endtask

   initial begin
      tests         = 0;
      fails         = 0;
      rst           = 1'b1;
      bus.in_valid  = 1'b0;
      bus.in_x      = '0;
      bus.in_w      = '0;
      bus.out_ready = 1'b1;
      test_reset();
      test_basic();
      test_negative();
      test_wrap();
      test_gaps();
      test_backpressure();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
